// File: rtl/riskbes_mem_pkg.sv
// Shared constants, FSM encoding and the alignment rule for the MEM stage.
// The alignment rule is used by the stage and by anything else that needs to classify an access.
package riskbes_mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  localparam logic [3:0] CAUSE_LOAD_MISALIGNED  = 4'd4;
  localparam logic [3:0] CAUSE_LOAD_FAULT       = 4'd5;
  localparam logic [3:0] CAUSE_STORE_MISALIGNED = 4'd6;
  localparam logic [3:0] CAUSE_STORE_FAULT      = 4'd7;

  // Unsupported size encodings are folded into "misaligned" so they never reach the bus.
  function automatic logic is_misaligned(input logic       is_load,
                                         input logic       is_store,
                                         input logic [2:0] funct3,
                                         input logic [1:0] offset);
    logic mis;
    mis = 1'b0;
    if (is_load) begin
      case (funct3)
        F3_LB, F3_LBU: mis = 1'b0;
        F3_LH, F3_LHU: mis = offset[0];
        F3_LW:         mis = (offset != 2'b00);
        default:       mis = 1'b1;
      endcase
    end else if (is_store) begin
      case (funct3)
        F3_SB:   mis = 1'b0;
        F3_SH:   mis = offset[0];
        F3_SW:   mis = (offset != 2'b00);
        default: mis = 1'b1;
      endcase
    end
    return mis;
  endfunction

endpackage

// File: rtl/load_data_aligner.sv
// Selects the addressed byte/half of a returned read word and extends it to 32 bits.
module load_data_aligner
  import riskbes_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Legal word accesses have offset 0, so the shifted word is the raw word for LW.
  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (funct3)
      F3_LB:   data = {{24{shifted[7]}}, shifted[7:0]};
      F3_LBU:  data = {24'b0, shifted[7:0]};
      F3_LH:   data = {{16{shifted[15]}}, shifted[15:0]};
      F3_LHU:  data = {16'b0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: drives the data-memory request/ack handshake and registers MEM/WB.
// Handshake: mem_req_o rises with a legal access and, with we/addr/wdata/wstrb, stays stable until mem_ack_i is sampled high or the ack timeout expires.
module memory_access_stage
  import riskbes_mem_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255,
  parameter int ADDR_W      = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       alu_out_ex_mem_i,
  input  logic [31:0]       rs2_ex_mem_i,
  input  logic [4:0]        rd_ex_mem_i,
  input  logic [1:0]        wb_sel_ex_mem_i,
  input  logic [2:0]        funct3_ex_mem_i,
  input  logic              is_load_instr_ex_mem_i,
  input  logic              is_store_instr_ex_mem_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wstrb_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              busywait_o,
  output logic [4:0]        rd_mem_wb_o,
  output logic [31:0]       alu_out_mem_wb_o,
  output logic [31:0]       rd_data_mem_wb_o,
  output logic [1:0]        wb_sel_mem_wb_o,
  output logic              is_load_instr_mem_wb_o,
  output logic              exception_o,
  output logic [3:0]        exception_cause_o,
  output mem_state_e        state_o
);

  localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  mem_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fault_q;
  logic [31:0]      alu_q;
  logic [31:0]      wdata_q;
  logic [3:0]       wstrb_q;
  logic             we_q;
  logic [2:0]       funct3_q;
  logic [4:0]       rd_q;
  logic [1:0]       wb_sel_q;
  logic             load_q;
  logic [31:0]      rdata_q;

  logic        access;
  logic        mis;
  logic [1:0]  offset;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] aligned;
  logic        start;
  logic        ack_take;
  logic        timeout;

  assign access = is_load_instr_ex_mem_i | is_store_instr_ex_mem_i;
  assign offset = alu_out_ex_mem_i[1:0];
  assign mis    = is_misaligned(is_load_instr_ex_mem_i, is_store_instr_ex_mem_i,
                                funct3_ex_mem_i, offset);
  assign state_o = state_q;

  always_comb begin
    st_wstrb = 4'b1111;
    st_wdata = rs2_ex_mem_i;
    case (funct3_ex_mem_i[1:0])
      2'b00: begin
        st_wstrb = 4'b0001 << offset;
        st_wdata = {4{rs2_ex_mem_i[7:0]}};
      end
      2'b01: begin
        st_wstrb = 4'b0011 << offset;
        st_wdata = {2{rs2_ex_mem_i[15:0]}};
      end
      default: begin
        st_wstrb = 4'b1111;
        st_wdata = rs2_ex_mem_i;
      end
    endcase
  end

  load_data_aligner u_aligner (
    .rdata  (mem_rdata_i),
    .offset (alu_q[1:0]),
    .funct3 (funct3_q),
    .data   (aligned)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = alu_out_ex_mem_i[ADDR_W-1:2];
    mem_wdata_o = st_wdata;
    mem_wstrb_o = 4'b0000;
    busywait_o  = 1'b0;
    start       = 1'b0;
    ack_take    = 1'b0;
    timeout     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !mis) begin
          mem_req_o   = 1'b1;
          mem_we_o    = is_store_instr_ex_mem_i;
          mem_wstrb_o = is_store_instr_ex_mem_i ? st_wstrb : 4'b0000;
          busywait_o  = 1'b1;
          start       = 1'b1;
          state_d     = ST_WAIT;
        end
      end
      ST_WAIT: begin
        mem_req_o   = 1'b1;
        mem_we_o    = we_q;
        mem_addr_o  = alu_q[ADDR_W-1:2];
        mem_wdata_o = wdata_q;
        mem_wstrb_o = wstrb_q;
        busywait_o  = 1'b1;
        if (mem_ack_i) begin
          ack_take = 1'b1;
          state_d  = ST_DONE;
        end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
          timeout = 1'b1;
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q                  <= '0;
      fault_q                <= 1'b0;
      alu_q                  <= '0;
      wdata_q                <= '0;
      wstrb_q                <= '0;
      we_q                   <= 1'b0;
      funct3_q               <= '0;
      rd_q                   <= '0;
      wb_sel_q               <= '0;
      load_q                 <= 1'b0;
      rdata_q                <= '0;
      rd_mem_wb_o            <= '0;
      alu_out_mem_wb_o       <= '0;
      rd_data_mem_wb_o       <= '0;
      wb_sel_mem_wb_o        <= '0;
      is_load_instr_mem_wb_o <= 1'b0;
      exception_o            <= 1'b0;
      exception_cause_o      <= '0;
    end else begin
      // The exception flag is a pulse; it only survives the cycle it is captured in.
      exception_o       <= 1'b0;
      exception_cause_o <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            alu_q    <= alu_out_ex_mem_i;
            wdata_q  <= st_wdata;
            wstrb_q  <= is_store_instr_ex_mem_i ? st_wstrb : 4'b0000;
            we_q     <= is_store_instr_ex_mem_i;
            funct3_q <= funct3_ex_mem_i;
            rd_q     <= rd_ex_mem_i;
            wb_sel_q <= wb_sel_ex_mem_i;
            load_q   <= is_load_instr_ex_mem_i;
          end else begin
            rd_mem_wb_o            <= (access && mis) ? 5'd0 : rd_ex_mem_i;
            alu_out_mem_wb_o       <= alu_out_ex_mem_i;
            rd_data_mem_wb_o       <= '0;
            wb_sel_mem_wb_o        <= wb_sel_ex_mem_i;
            is_load_instr_mem_wb_o <= is_load_instr_ex_mem_i;
            if (access && mis) begin
              exception_o       <= 1'b1;
              exception_cause_o <= is_load_instr_ex_mem_i ? CAUSE_LOAD_MISALIGNED
                                                          : CAUSE_STORE_MISALIGNED;
            end
          end
        end
        ST_WAIT: begin
          if (ack_take)     rdata_q <= aligned;
          else if (timeout) fault_q <= 1'b1;
          else              cnt_q   <= cnt_q + CNT_W'(1);
        end
        ST_DONE: begin
          rd_mem_wb_o            <= fault_q ? 5'd0 : rd_q;
          alu_out_mem_wb_o       <= alu_q;
          rd_data_mem_wb_o       <= (fault_q || !load_q) ? 32'd0 : rdata_q;
          wb_sel_mem_wb_o        <= wb_sel_q;
          is_load_instr_mem_wb_o <= load_q;
          if (fault_q) begin
            exception_o       <= 1'b1;
            exception_cause_o <= load_q ? CAUSE_LOAD_FAULT : CAUSE_STORE_FAULT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed and random loads/stores with a MEM/WB scoreboard.
module tb_memory_access_stage;
  import riskbes_mem_pkg::*;

  localparam int ACK_TO = 4;
  localparam int EXP_W  = 77;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] alu_out_ex_mem_i;
  logic [31:0] rs2_ex_mem_i;
  logic [4:0]  rd_ex_mem_i;
  logic [1:0]  wb_sel_ex_mem_i;
  logic [2:0]  funct3_ex_mem_i;
  logic        is_load_instr_ex_mem_i;
  logic        is_store_instr_ex_mem_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [29:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        busywait_o;
  logic [4:0]  rd_mem_wb_o;
  logic [31:0] alu_out_mem_wb_o;
  logic [31:0] rd_data_mem_wb_o;
  logic [1:0]  wb_sel_mem_wb_o;
  logic        is_load_instr_mem_wb_o;
  logic        exception_o;
  logic [3:0]  exception_cause_o;
  mem_state_e  state_o;

  int n_checks = 0;
  int n_err    = 0;
  logic [EXP_W-1:0] exp_q[$];

  memory_access_stage #(.ACK_TIMEOUT(ACK_TO), .ADDR_W(32)) dut (
    .clk_i                   (clk_i),
    .rst_i                   (rst_i),
    .alu_out_ex_mem_i        (alu_out_ex_mem_i),
    .rs2_ex_mem_i            (rs2_ex_mem_i),
    .rd_ex_mem_i             (rd_ex_mem_i),
    .wb_sel_ex_mem_i         (wb_sel_ex_mem_i),
    .funct3_ex_mem_i         (funct3_ex_mem_i),
    .is_load_instr_ex_mem_i  (is_load_instr_ex_mem_i),
    .is_store_instr_ex_mem_i (is_store_instr_ex_mem_i),
    .mem_req_o               (mem_req_o),
    .mem_we_o                (mem_we_o),
    .mem_addr_o              (mem_addr_o),
    .mem_wdata_o             (mem_wdata_o),
    .mem_wstrb_o             (mem_wstrb_o),
    .mem_ack_i               (mem_ack_i),
    .mem_rdata_i             (mem_rdata_i),
    .busywait_o              (busywait_o),
    .rd_mem_wb_o             (rd_mem_wb_o),
    .alu_out_mem_wb_o        (alu_out_mem_wb_o),
    .rd_data_mem_wb_o        (rd_data_mem_wb_o),
    .wb_sel_mem_wb_o         (wb_sel_mem_wb_o),
    .is_load_instr_mem_wb_o  (is_load_instr_mem_wb_o),
    .exception_o             (exception_o),
    .exception_cause_o       (exception_cause_o),
    .state_o                 (state_o)
  );

  // Clock and watchdog
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model
  function automatic logic exp_mis(input logic ld, input logic st, input logic [2:0] f3,
                                   input logic [1:0] a);
    if (ld) begin
      if (f3 == 3'b000 || f3 == 3'b100) return 1'b0;
      if (f3 == 3'b001 || f3 == 3'b101) return a[0];
      if (f3 == 3'b010) return a != 2'b00;
      return 1'b1;
    end
    if (st) begin
      if (f3 == 3'b000) return 1'b0;
      if (f3 == 3'b001) return a[0];
      if (f3 == 3'b010) return a != 2'b00;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'h0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] exp_strb(input logic [2:0] f3, input logic [1:0] a);
    case (f3)
      3'b000: case (a)
        2'd0: return 4'b0001;
        2'd1: return 4'b0010;
        2'd2: return 4'b0100;
        default: return 4'b1000;
      endcase
      3'b001: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'b000: return {v[7:0], v[7:0], v[7:0], v[7:0]};
      3'b001: return {v[15:0], v[15:0]};
      default: return v;
    endcase
  endfunction

  // Driver tasks
  task automatic drive_nop();
    alu_out_ex_mem_i        = '0;
    rs2_ex_mem_i            = '0;
    rd_ex_mem_i             = '0;
    wb_sel_ex_mem_i         = '0;
    funct3_ex_mem_i         = '0;
    is_load_instr_ex_mem_i  = 1'b0;
    is_store_instr_ex_mem_i = 1'b0;
    mem_ack_i               = 1'b0;
  endtask

  task automatic compare_wb();
    logic [EXP_W-1:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'(exp_q.size()), 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("wb_rd",    32'(rd_mem_wb_o),            32'(e[76:72]));
    check("wb_alu",   alu_out_mem_wb_o,            e[71:40]);
    check("wb_data",  rd_data_mem_wb_o,            e[39:8]);
    check("wb_sel",   32'(wb_sel_mem_wb_o),        32'(e[7:6]));
    check("wb_load",  32'(is_load_instr_mem_wb_o), 32'(e[5]));
    check("wb_exc",   32'(exception_o),            32'(e[4]));
    check("wb_cause", 32'(exception_cause_o),      32'(e[3:0]));
  endtask

  // ack_at: WAIT cycle (1-based) in which ack is presented; 0 means never.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [4:0] rd,
                        input logic [1:0] wb, input logic [2:0] f3, input logic ld,
                        input logic st, input int ack_at, input logic [31:0] rdata);
    logic        access, mis, legal, done;
    logic [31:0] data;
    int          busy_cnt, k;
    access = ld | st;
    mis    = exp_mis(ld, st, f3, alu[1:0]);
    legal  = access && !mis;
    @(negedge clk_i);
    alu_out_ex_mem_i        = alu;
    rs2_ex_mem_i            = rs2;
    rd_ex_mem_i             = rd;
    wb_sel_ex_mem_i         = wb;
    funct3_ex_mem_i         = f3;
    is_load_instr_ex_mem_i  = ld;
    is_store_instr_ex_mem_i = st;
    mem_ack_i               = 1'b0;
    if (!access)
      exp_q.push_back({rd, alu, 32'd0, wb, 1'b0, 1'b0, 4'd0});
    else if (mis)
      exp_q.push_back({5'd0, alu, 32'd0, wb, ld, 1'b1, ld ? 4'd4 : 4'd6});
    else if (ack_at == 0)
      exp_q.push_back({5'd0, alu, 32'd0, wb, ld, 1'b1, ld ? 4'd5 : 4'd7});
    else begin
      data = ld ? exp_ext(rdata, alu[1:0], f3) : 32'd0;
      exp_q.push_back({rd, alu, data, wb, ld, 1'b0, 4'd0});
    end
    #1;
    if (!legal) begin
      check("req_none", 32'(mem_req_o), 32'd0);
      check("busy_none", 32'(busywait_o), 32'd0);
      @(negedge clk_i);
      drive_nop();
      compare_wb();
    end else begin
      check("req_idle", 32'(mem_req_o), 32'd1);
      check("busy_idle", 32'(busywait_o), 32'd1);
      check("addr", 32'(mem_addr_o), {2'b00, alu[31:2]});
      check("we", 32'(mem_we_o), 32'(st));
      if (st) begin
        check("wstrb", 32'(mem_wstrb_o), 32'(exp_strb(f3, alu[1:0])));
        check("wdata", mem_wdata_o, exp_wdata(f3, rs2));
      end
      busy_cnt = 1;
      k        = 0;
      done     = 1'b0;
      for (int g = 0; g < 20 && !done; g++) begin
        @(negedge clk_i);
        if (!busywait_o) done = 1'b1;
        else begin
          busy_cnt++;
          k++;
          mem_ack_i   = (k == ack_at);
          mem_rdata_i = (k == ack_at) ? rdata : $urandom();
          if (k == 1) begin
            check("req_hold", 32'(mem_req_o), 32'd1);
            check("addr_hold", 32'(mem_addr_o), {2'b00, alu[31:2]});
            check("we_hold", 32'(mem_we_o), 32'(st));
          end
        end
      end
      check("wait_bound", 32'(done), 32'd1);
      check("busy_cycles", busy_cnt, (ack_at == 0) ? ACK_TO + 1 : ack_at + 1);
      check("req_done", 32'(mem_req_o), 32'd0);
      drive_nop();
      @(negedge clk_i);
      compare_wb();
    end
    @(negedge clk_i);
    check("exc_pulse", 32'(exception_o), 32'd0);
  endtask

  initial begin
    rst_i       = 1'b1;
    mem_rdata_i = '0;
    drive_nop();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst_state", 32'(state_o), 32'(ST_IDLE));
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_busy", 32'(busywait_o), 32'd0);
    check("rst_rd", 32'(rd_mem_wb_o), 32'd0);
    check("rst_alu", alu_out_mem_wb_o, 32'd0);
    check("rst_exc", 32'(exception_o), 32'd0);

    // alu, rs2, rd, wb, f3, ld, st, ack_at, rdata
    run_op(32'h1234, 32'h0,     5'd5,  2'd1, 3'b000, 1'b0, 1'b0, 0, 32'h0);
    run_op(32'h103,  32'hAB,    5'd0,  2'd0, F3_SB,  1'b0, 1'b1, 2, 32'h0);
    run_op(32'h202,  32'h0,     5'd6,  2'd2, F3_LB,  1'b1, 1'b0, 1, 32'h0080_0000);
    run_op(32'h202,  32'h0,     5'd7,  2'd2, F3_LBU, 1'b1, 1'b0, 1, 32'h0080_0000);
    run_op(32'h302,  32'h0,     5'd8,  2'd2, F3_LW,  1'b1, 1'b0, 1, 32'h0);
    run_op(32'h400,  32'h0,     5'd9,  2'd2, F3_LW,  1'b1, 1'b0, 0, 32'h0);
    run_op(32'h101,  32'h55AA,  5'd0,  2'd0, F3_SH,  1'b0, 1'b1, 1, 32'h0);
    run_op(32'h500,  32'hCAFE,  5'd0,  2'd0, F3_SW,  1'b0, 1'b1, 0, 32'h0);
    run_op(32'h206,  32'h0,     5'd10, 2'd2, F3_LH,  1'b1, 1'b0, 3, 32'h8001_0000);
    run_op(32'h206,  32'h0,     5'd11, 2'd2, F3_LHU, 1'b1, 1'b0, 2, 32'h8001_0000);
    run_op(32'h600,  32'h0,     5'd0,  2'd2, F3_LW,  1'b1, 1'b0, 1, 32'hDEAD_BEEF);
    run_op(32'h700,  32'h0,     5'd12, 2'd2, 3'b011, 1'b1, 1'b0, 1, 32'h0);
    run_op(32'h800,  32'h0,     5'd0,  2'd0, 3'b100, 1'b0, 1'b1, 1, 32'h0);

    for (int i = 0; i < 12; i++) begin
      logic        st;
      logic [2:0]  f3;
      logic [31:0] a;
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 2));
      if (!st && f3 != 3'b010 && $urandom_range(0, 1) == 1) f3[2] = 1'b1;
      a = {14'h0, 16'($urandom_range(0, 16'hFFFF)), 2'b00};
      if (f3[1:0] == 2'b00) a[1:0] = 2'($urandom_range(0, 3));
      else if (f3[1:0] == 2'b01) a[1] = 1'($urandom_range(0, 1));
      run_op(a, $urandom(), 5'($urandom_range(1, 31)), 2'($urandom_range(0, 3)), f3,
             !st, st, $urandom_range(1, 3), $urandom());
    end

    // Reset while waiting: the access is abandoned and a late ack is ignored.
    @(negedge clk_i);
    alu_out_ex_mem_i       = 32'h900;
    rd_ex_mem_i            = 5'd13;
    funct3_ex_mem_i        = F3_LW;
    is_load_instr_ex_mem_i = 1'b1;
    repeat (2) @(negedge clk_i);
    check("rw_busy", 32'(busywait_o), 32'd1);
    rst_i = 1'b1;
    drive_nop();
    @(negedge clk_i);
    rst_i       = 1'b0;
    mem_ack_i   = 1'b1;
    mem_rdata_i = 32'hFFFF_FFFF;
    #1;
    check("rw_state", 32'(state_o), 32'(ST_IDLE));
    check("rw_req", 32'(mem_req_o), 32'd0);
    check("rw_busy0", 32'(busywait_o), 32'd0);
    check("rw_rd", 32'(rd_mem_wb_o), 32'd0);
    check("rw_data", rd_data_mem_wb_o, 32'd0);
    @(negedge clk_i);
    mem_ack_i = 1'b0;
    check("rw_late_state", 32'(state_o), 32'(ST_IDLE));
    check("rw_late_data", rd_data_mem_wb_o, 32'd0);
    check("rw_late_exc", 32'(exception_o), 32'd0);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
